// File: rtl/div_clk_tick_rx_if.sv
// Divided-clock receive bus: incoming divided clock plus the recovered ticks,
// half-period measurement and lock status.
interface div_clk_tick_rx_if #(
  parameter int CNT_W = 8
);
  logic             div_clk_in;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] half_period;
  logic             locked;
  logic             lost;
  logic [7:0]       err_cnt;

  modport master (
    output div_clk_in,
    input  tick_rise, tick_fall, half_period, locked, lost, err_cnt
  );

  modport slave (
    input  div_clk_in,
    output tick_rise, tick_fall, half_period, locked, lost, err_cnt
  );
endinterface

// File: rtl/div_clk_tick_rx.sv
// Divided-clock receiver: synchronise, tick on edges, measure half-period, track lock.
// Optional macro DIV_TICK_GATE_EN: ticks only pass while the FSM is LOCKED.
module div_clk_tick_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int EXP_HALF    = 5,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  div_clk_tick_rx_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, LOST} state_e;

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  LO_LIM  = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0]  HI_LIM  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0]  TMO     = CNT_W'(2 * (EXP_HALF + TOL));
  localparam logic [GOOD_W-1:0] GOOD_LK = GOOD_W'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   det_rise_q, det_rise_d, det_fall_q, det_fall_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic [CNT_W-1:0]       half_period_q, half_period_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   locked_q, locked_d, lost_q, lost_d;
  logic                   tick_rise_q, tick_rise_d, tick_fall_q, tick_fall_d;

  logic             edge_det, in_range, gate_ok;
  logic [CNT_W:0]   interval;
  logic [CNT_W-1:0] iv_sat;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.div_clk_in};
    hist_d     = sync_q[SYNC_STAGES-1];
    det_rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    det_fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;

    // The registered edge flags mark the detection cycle used by counter and FSM.
    edge_det = det_rise_q | det_fall_q;
    interval = {1'b0, cnt_q} + (CNT_W+1)'(1);
    iv_sat   = interval[CNT_W] ? CNT_MAX : interval[CNT_W-1:0];
    in_range = (iv_sat >= LO_LIM) && (iv_sat <= HI_LIM);

    if (edge_det)              cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);

`ifdef DIV_TICK_GATE_EN
    gate_ok = (state_q == LOCKED);
`else
    gate_ok = 1'b1;
`endif
    tick_rise_d = det_rise_q & gate_ok;
    tick_fall_d = det_fall_q & gate_ok;
    locked_d    = (state_q == LOCKED);
    lost_d      = (state_q == LOST);
  end

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    half_period_d = half_period_q;
    err_cnt_d     = err_cnt_q;
    if (edge_det) begin
      unique case (state_q)
        SEARCH, LOST: begin
          // Edge after no reference: its interval is meaningless.
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          half_period_d = iv_sat;
          if (in_range) begin
            good_d = good_q + GOOD_W'(1);
            if (good_q + GOOD_W'(1) == GOOD_LK) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          half_period_d = iv_sat;
          if (!in_range) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if ((state_q == ACQUIRE || state_q == LOCKED) && cnt_q == TMO) begin
      state_d = LOST;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sync_q        <= '0;
      hist_q        <= 1'b0;
      det_rise_q    <= 1'b0;
      det_fall_q    <= 1'b0;
      cnt_q         <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      half_period_q <= '0;
      err_cnt_q     <= '0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      tick_rise_q   <= 1'b0;
      tick_fall_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      det_rise_q    <= det_rise_d;
      det_fall_q    <= det_fall_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      good_q        <= good_d;
      half_period_q <= half_period_d;
      err_cnt_q     <= err_cnt_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      tick_rise_q   <= tick_rise_d;
      tick_fall_q   <= tick_fall_d;
    end
  end

  assign bus.tick_rise   = tick_rise_q;
  assign bus.tick_fall   = tick_fall_q;
  assign bus.half_period = half_period_q;
  assign bus.locked      = locked_q;
  assign bus.lost        = lost_q;
  assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_div_clk_tick_rx.sv
// Bench for div_clk_tick_rx: event-level model compared every cycle, plus literal pins.
module tb_div_clk_tick_rx;
  localparam int M_SRCH = 0, M_ACQ = 1, M_LCK = 2, M_LST = 3;

  logic clk_in = 1'b0;
  logic rst_in;
  int   errors = 0;
  int   checks = 0;

  div_clk_tick_rx_if #(.CNT_W(8)) bus ();

  div_clk_tick_rx dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Inputs as the DUT saw them at the last rising edge.
  bit s_div, s_rst;
  always @(posedge clk_in) begin
    s_div <= bus.div_clk_in;
    s_rst <= rst_in;
  end

  // Model: edge of the input seen at sample k-3 vs k-4; interval is the
  // distance in cycles between processed edges; timeout 13 cycles after one.
  initial begin
    int k, k0, good, hp, err, mst, iv;
    bit h[5];
    bit rise, fall, gate, inr, e_tr, e_tf, e_lk, e_ls;
    k = 0; k0 = 0; good = 0; hp = 0; err = 0; mst = M_SRCH;
    e_tr = 0; e_tf = 0; e_lk = 0; e_ls = 0;
    forever begin
      @(negedge clk_in);
      k++;
      if (!s_rst) begin
        for (int i = 0; i < 5; i++) h[i] = 1'b0;
        mst = M_SRCH; k0 = k; good = 0; hp = 0; err = 0;
        e_tr = 0; e_tf = 0; e_lk = 0; e_ls = 0;
      end else begin
        for (int i = 4; i > 0; i--) h[i] = h[i-1];
        h[0] = s_div;
        rise = h[3] && !h[4];
        fall = !h[3] && h[4];
`ifdef DIV_TICK_GATE_EN
        gate = (mst == M_LCK);
`else
        gate = 1'b1;
`endif
        e_tr = rise && gate;
        e_tf = fall && gate;
        e_lk = (mst == M_LCK);
        e_ls = (mst == M_LST);
        if (rise || fall) begin
          iv  = (k - k0 > 255) ? 255 : k - k0;
          inr = (iv >= 4) && (iv <= 6);
          if (mst == M_SRCH || mst == M_LST) begin
            mst = M_ACQ; good = 0;
          end else if (mst == M_ACQ) begin
            hp = iv;
            if (inr) begin
              good++;
              if (good == 4) mst = M_LCK;
            end else good = 0;
          end else begin
            hp = iv;
            if (!inr) begin
              if (err < 255) err++;
              mst = M_ACQ; good = 0;
            end
          end
          k0 = k;
        end else if ((mst == M_ACQ || mst == M_LCK) && (k - k0 == 13)) begin
          mst = M_LST;
        end
      end
      chk("tick_rise", int'(bus.tick_rise), int'(e_tr));
      chk("tick_fall", int'(bus.tick_fall), int'(e_tf));
      chk("locked", int'(bus.locked), int'(e_lk));
      chk("lost", int'(bus.lost), int'(e_ls));
      chk("half_period", int'(bus.half_period), hp);
      chk("err_cnt", int'(bus.err_cnt), err);
    end
  end

  task automatic tog(input int n, input int times);
    repeat (times) begin
      repeat (n) @(posedge clk_in);
      #1 bus.div_clk_in = ~bus.div_clk_in;
    end
  endtask

  initial begin
    rst_in = 1'b0;
    bus.div_clk_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    chk("pin_reset_locked", int'(bus.locked), 0);
    chk("pin_reset_hp", int'(bus.half_period), 0);

    // Lock-up
    tog(5, 10);
    chk("pin_lock", int'(bus.locked), 1);
    chk("pin_lock_hp", int'(bus.half_period), 5);
    chk("pin_lock_err", int'(bus.err_cnt), 0);

    // Tick latency: rise first sampled at N shows at N+3 only
    repeat (5) @(posedge clk_in);
    #1 bus.div_clk_in = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("pin_tick_early", int'(bus.tick_rise), 0);
    @(negedge clk_in);
    chk("pin_tick_on", int'(bus.tick_rise), 1);
    @(negedge clk_in);
    chk("pin_tick_off", int'(bus.tick_rise), 0);
    bus.div_clk_in = 1'b0;
    tog(5, 4);

    // Tolerance
    tog(6, 1);
    tog(4, 1);
    chk("pin_tol_hp6", int'(bus.half_period), 6);
    tog(5, 1);
    chk("pin_tol_hp4", int'(bus.half_period), 4);
    chk("pin_tol_locked", int'(bus.locked), 1);
    tog(5, 4);

    // Glitch
    tog(2, 1);
    tog(5, 1);
    chk("pin_glitch_hp", int'(bus.half_period), 2);
    chk("pin_glitch_err", int'(bus.err_cnt), 1);
    chk("pin_glitch_unlock", int'(bus.locked), 0);
    tog(5, 6);
    chk("pin_glitch_relock", int'(bus.locked), 1);

    // Loss
    repeat (30) @(posedge clk_in);
    #1;
    chk("pin_loss_lost", int'(bus.lost), 1);
    chk("pin_loss_locked", int'(bus.locked), 0);
    tog(5, 8);
    chk("pin_loss_clear", int'(bus.lost), 0);
    chk("pin_loss_relock", int'(bus.locked), 1);

    // Two more glitches, then reset mid-lock
    tog(2, 1); tog(5, 8);
    tog(2, 1); tog(5, 8);
    chk("pin_err3", int'(bus.err_cnt), 3);
    chk("pin_err3_locked", int'(bus.locked), 1);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    chk("pin_rst_err", int'(bus.err_cnt), 0);
    chk("pin_rst_locked", int'(bus.locked), 0);
    chk("pin_rst_hp", int'(bus.half_period), 0);
    tog(5, 10);
    chk("pin_rst_relock", int'(bus.locked), 1);
    repeat (4) @(posedge clk_in);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
